perf_monitor: RTL and testbench

PERF_MONITOR -- requirements
Module: perf_monitor

---
 rtl/perf_pkg.sv | 30 +++
 rtl/perf_monitor_if.sv | 44 ++++
 rtl/perf_counter.sv | 39 +++
 rtl/perf_monitor.sv | 160 ++++++++++++++++
 tb/tb_perf_monitor.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance monitor: FSM state encoding,
// width helpers and fixed widths of the cycle counter and read bus.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FROZEN = 2'b10
  } perf_state_e;

  // Cycle counter and read bus are always 64 bits wide.
  localparam int CYC_CNT_W = 64;
  localparam int RD_DATA_W = 64;

  // The cycle counter sits on the read index one past the last event counter.
  // For the default four-counter build that is index 4.
  localparam int DEF_NUM_CNT = 4;
  localparam int CYC_IDX     = DEF_NUM_CNT;

  // Width of one per-event increment field able to hold 0..commit_w.
  function automatic int inc_width(input int commit_w);
    return (commit_w < 1) ? 1 : $clog2(commit_w + 1);
  endfunction

  // Index width for n selectable items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/perf_monitor_if.sv
// Control, event, configuration and read signals of the performance monitor.
// The master side (core / software model) drives requests and events, the
// slave side (perf_monitor) returns read data and status.
interface perf_monitor_if
  import perf_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int NUM_EVT = 8,
  parameter int INC_W   = 2
);

  localparam int CFG_IDX_W = idx_width(NUM_CNT);
  localparam int SEL_W     = idx_width(NUM_EVT);
  localparam int RD_IDX_W  = idx_width(NUM_CNT + 1);

  logic                       start_i;
  logic                       stop_i;
  logic                       halt_i;
  logic                       clear_i;
  logic [NUM_EVT*INC_W-1:0]   evt_inc_i;
  logic                       cfg_we_i;
  logic [CFG_IDX_W-1:0]       cfg_idx_i;
  logic [SEL_W-1:0]           cfg_sel_i;
  logic                       rd_req_i;
  logic [RD_IDX_W-1:0]        rd_idx_i;
  logic                       rd_valid_o;
  logic [RD_DATA_W-1:0]       rd_data_o;
  logic                       rd_ovf_o;
  logic [1:0]                 state_o;
  logic                       done_o;

  modport master (
    output start_i, stop_i, halt_i, clear_i, evt_inc_i,
           cfg_we_i, cfg_idx_i, cfg_sel_i, rd_req_i, rd_idx_i,
    input  rd_valid_o, rd_data_o, rd_ovf_o, state_o, done_o
  );

  modport slave (
    input  start_i, stop_i, halt_i, clear_i, evt_inc_i,
           cfg_we_i, cfg_idx_i, cfg_sel_i, rd_req_i, rd_idx_i,
    output rd_valid_o, rd_data_o, rd_ovf_o, state_o, done_o
  );

endinterface

// File: rtl/perf_counter.sv
// One programmable event counter. Adds a small increment while enabled and
// either saturates at all-ones or wraps; any carry out sets a sticky flag.
module perf_counter #(
  parameter int CNT_W    = 40,
  parameter int INC_W    = 2,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [CNT_W:0] sum;

  assign sum = {1'b0, count} + (CNT_W+1)'(inc);

  // Accumulate while enabled; clear wins over counting in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      if (sum[CNT_W]) begin
        ovf   <= 1'b1;
        count <= (SATURATE != 0) ? '1 : sum[CNT_W-1:0];
      end else begin
        count <= sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Performance monitor: IDLE/RUN/FROZEN control FSM, a free 64-bit cycle
// counter, NUM_CNT event counters bound to selectable event inputs, and a
// one-cycle-latency read port covering all counters.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_CNT  = 4,
  parameter int NUM_EVT  = 8,
  parameter int COMMIT_W = 2,
  parameter int CNT_W    = 40,
  parameter int SATURATE = 1
) (
  input  logic           clk,
  input  logic           rst,
  perf_monitor_if.slave  bus
);

  localparam int INC_W     = inc_width(COMMIT_W);
  localparam int CFG_IDX_W = idx_width(NUM_CNT);
  localparam int SEL_W     = idx_width(NUM_EVT);
  localparam int EVT_PAD_W = (1 << SEL_W) * INC_W;

  perf_state_e            state_q;
  perf_state_e            state_d;
  logic                   run_en;
  logic [CYC_CNT_W-1:0]   cycle_q;
  logic [SEL_W-1:0]       sel [NUM_CNT];
  logic                   cfg_idx_ok;
  logic                   cfg_write;
  logic [EVT_PAD_W-1:0]   evt_pad;
  logic [CNT_W-1:0]       cnt [NUM_CNT];
  logic [NUM_CNT-1:0]     ovf;
  logic                   rd_valid_q;
  logic [RD_DATA_W-1:0]   rd_data_q;
  logic                   rd_ovf_q;
  logic [RD_DATA_W-1:0]   rd_data_d;
  logic                   rd_ovf_d;

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clear beats stop/halt, which beat start; each request is
  // only honoured in the state where it makes sense.
  always_comb begin
    state_d = state_q;
    if (bus.clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (bus.start_i)                state_d = ST_RUN;
        ST_RUN:    if (bus.stop_i || bus.halt_i)   state_d = ST_FROZEN;
        ST_FROZEN: state_d = ST_FROZEN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Counting follows the registered state, so the stop/halt cycle still counts.
  assign run_en = (state_q == ST_RUN);

  // Free-running cycle counter while in RUN; wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
    end else if (bus.clear_i) begin
      cycle_q <= '0;
    end else if (run_en) begin
      cycle_q <= cycle_q + 64'd1;
    end
  end

  // Out-of-range counter indices only exist when NUM_CNT is not a power of two.
  if ((1 << CFG_IDX_W) == NUM_CNT) begin : g_idx_full
    assign cfg_idx_ok = 1'b1;
  end else begin : g_idx_part
    assign cfg_idx_ok = (int'(bus.cfg_idx_i) < NUM_CNT);
  end

  assign cfg_write = bus.cfg_we_i && cfg_idx_ok && (state_q == ST_IDLE);

  // Event-select table; reset binds counter i to event i mod NUM_EVT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        sel[i] <= SEL_W'(i % NUM_EVT);
      end
    end else if (cfg_write) begin
      sel[bus.cfg_idx_i] <= bus.cfg_sel_i;
    end
  end

  // Pad the event vector so any select value lands on a defined (zero) field.
  always_comb begin
    evt_pad = '0;
    evt_pad[NUM_EVT*INC_W-1:0] = bus.evt_inc_i;
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    logic [INC_W-1:0] inc;

    assign inc = evt_pad[sel[g]*INC_W +: INC_W];

    perf_counter #(
      .CNT_W    (CNT_W),
      .INC_W    (INC_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.clear_i),
      .en    (run_en),
      .inc   (inc),
      .count (cnt[g]),
      .ovf   (ovf[g])
    );
  end

  // Read mux: event counters, then the cycle counter, zero beyond that.
  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (int'(bus.rd_idx_i) == i) begin
        rd_data_d = RD_DATA_W'(cnt[i]);
        rd_ovf_d  = ovf[i];
      end
    end
    if (int'(bus.rd_idx_i) == NUM_CNT) begin
      rd_data_d = cycle_q;
    end
  end

  // Read response register: one result per request, one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_req_i;
      if (bus.rd_req_i) begin
        rd_data_q <= rd_data_d;
        rd_ovf_q  <= rd_ovf_d;
      end
    end
  end

  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_ovf_o   = rd_ovf_q;
  assign bus.state_o    = state_q;
  assign bus.done_o     = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a saturating and a wrapping instance
// (CNT_W=8) share one stimulus stream; expected values are hand-computed.
module tb_perf_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, halt, clear, cfg_we, rd_req;
  logic [1:0]  cfg_idx;
  logic [2:0]  cfg_sel;
  logic [2:0]  rd_idx;
  logic [15:0] evt_inc;

  int total = 0;
  int bad   = 0;

  perf_monitor_if #(.NUM_CNT(4), .NUM_EVT(8), .INC_W(2)) bus_sat ();
  perf_monitor_if #(.NUM_CNT(4), .NUM_EVT(8), .INC_W(2)) bus_wrap ();

  assign bus_sat.start_i    = start;
  assign bus_sat.stop_i     = stop;
  assign bus_sat.halt_i     = halt;
  assign bus_sat.clear_i    = clear;
  assign bus_sat.evt_inc_i  = evt_inc;
  assign bus_sat.cfg_we_i   = cfg_we;
  assign bus_sat.cfg_idx_i  = cfg_idx;
  assign bus_sat.cfg_sel_i  = cfg_sel;
  assign bus_sat.rd_req_i   = rd_req;
  assign bus_sat.rd_idx_i   = rd_idx;
  assign bus_wrap.start_i   = start;
  assign bus_wrap.stop_i    = stop;
  assign bus_wrap.halt_i    = halt;
  assign bus_wrap.clear_i   = clear;
  assign bus_wrap.evt_inc_i = evt_inc;
  assign bus_wrap.cfg_we_i  = cfg_we;
  assign bus_wrap.cfg_idx_i = cfg_idx;
  assign bus_wrap.cfg_sel_i = cfg_sel;
  assign bus_wrap.rd_req_i  = rd_req;
  assign bus_wrap.rd_idx_i  = rd_idx;

  perf_monitor #(.NUM_CNT(4), .NUM_EVT(8), .COMMIT_W(2), .CNT_W(8), .SATURATE(1))
    dut_sat (.clk(clk), .rst(rst), .bus(bus_sat));

  perf_monitor #(.NUM_CNT(4), .NUM_EVT(8), .COMMIT_W(2), .CNT_W(8), .SATURATE(0))
    dut_wrap (.clk(clk), .rst(rst), .bus(bus_wrap));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_evt(input int k, input logic [1:0] v);
    evt_inc[2*k +: 2] = v;
  endtask

  task automatic do_read(input int idx, output logic [63:0] ds, output logic os,
                         output logic [63:0] dw, output logic ow, output logic v);
    rd_req = 1'b1;
    rd_idx = idx[2:0];
    step();
    ds = bus_sat.rd_data_o;
    os = bus_sat.rd_ovf_o;
    dw = bus_wrap.rd_data_o;
    ow = bus_wrap.rd_ovf_o;
    v  = bus_sat.rd_valid_o;
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] ds, dw;
    logic os, ow, v;
    rst = 1'b1;
    start = 0; stop = 0; halt = 0; clear = 0; cfg_we = 0; rd_req = 0;
    cfg_idx = '0; cfg_sel = '0; rd_idx = '0; evt_inc = '0;
    #2;
    total++;
    if (bus_sat.state_o !== 2'b00 || bus_sat.done_o !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_state: state=%b done=%b want 00/0", bus_sat.state_o, bus_sat.done_o);
    end
    total++;
    if (bus_sat.rd_valid_o !== 1'b0 || bus_sat.rd_data_o !== 64'd0 || bus_sat.rd_ovf_o !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_read: valid=%b data=%0d ovf=%b want 0/0/0",
                      bus_sat.rd_valid_o, bus_sat.rd_data_o, bus_sat.rd_ovf_o);
    end
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i <= 4; i++) begin
      do_read(i, ds, os, dw, ow, v);
      total++;
      if (v !== 1'b1 || ds !== 64'd0 || os !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_read_idx%0d: valid=%b data=%0d ovf=%b want 1/0/0", i, v, ds, os);
      end
    end
  endtask

  task automatic test_run_halt();
    logic [63:0] ds, dw;
    logic os, ow, v;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (bus_sat.state_o !== 2'b01) begin
      bad++; $display("[TB] FAIL run_entered: state=%b want 01", bus_sat.state_o);
    end
    set_evt(0, 2'd2);
    for (int c = 1; c <= 10; c++) begin
      halt = (c == 10);
      step();
    end
    halt = 1'b0;
    evt_inc = '0;
    total++;
    if (bus_sat.state_o !== 2'b10 || bus_sat.done_o !== 1'b1) begin
      bad++; $display("[TB] FAIL halt_frozen: state=%b done=%b want 10/1", bus_sat.state_o, bus_sat.done_o);
    end
    do_read(0, ds, os, dw, ow, v);
    total++;
    if (ds !== 64'd20 || dw !== 64'd20 || os !== 1'b0) begin
      bad++; $display("[TB] FAIL halt_cnt0: sat=%0d wrap=%0d ovf=%b want 20/20/0", ds, dw, os);
    end
    do_read(4, ds, os, dw, ow, v);
    total++;
    if (ds !== 64'd10 || dw !== 64'd10) begin
      bad++; $display("[TB] FAIL halt_cycle: sat=%0d wrap=%0d want 10", ds, dw);
    end
    do_read(1, ds, os, dw, ow, v);
    total++;
    if (ds !== 64'd0) begin
      bad++; $display("[TB] FAIL halt_cnt1: got %0d want 0", ds);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] ds, dw;
    logic os, ow, v;
    clear = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    set_evt(0, 2'd2);
    for (int c = 1; c <= 130; c++) begin
      stop = (c == 130);
      step();
    end
    stop = 1'b0;
    evt_inc = '0;
    do_read(0, ds, os, dw, ow, v);
    total++;
    if (ds !== 64'd255 || os !== 1'b1) begin
      bad++; $display("[TB] FAIL ovf_saturate: data=%0d ovf=%b want 255/1", ds, os);
    end
    total++;
    if (dw !== 64'd4 || ow !== 1'b1) begin
      bad++; $display("[TB] FAIL ovf_wrap: data=%0d ovf=%b want 4/1", dw, ow);
    end
    do_read(4, ds, os, dw, ow, v);
    total++;
    if (ds !== 64'd130 || os !== 1'b0) begin
      bad++; $display("[TB] FAIL ovf_cycle: data=%0d ovf=%b want 130/0", ds, os);
    end
    do_read(1, ds, os, dw, ow, v);
    total++;
    if (os !== 1'b0 || ow !== 1'b0) begin
      bad++; $display("[TB] FAIL ovf_cnt1_flag: sat=%b wrap=%b want 0/0", os, ow);
    end
  endtask

  task automatic test_clear_start();
    logic [63:0] ds, dw;
    logic os, ow, v;
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    total++;
    if (bus_sat.state_o !== 2'b00 || bus_sat.done_o !== 1'b0) begin
      bad++; $display("[TB] FAIL clear_start_state: state=%b done=%b want 00/0", bus_sat.state_o, bus_sat.done_o);
    end
    for (int i = 0; i <= 4; i++) begin
      do_read(i, ds, os, dw, ow, v);
      total++;
      if (ds !== 64'd0 || os !== 1'b0 || dw !== 64'd0 || ow !== 1'b0) begin
        bad++; $display("[TB] FAIL clear_read_idx%0d: sat=%0d/%b wrap=%0d/%b want 0/0", i, ds, os, dw, ow);
      end
    end
    total++;
    if (bus_sat.state_o !== 2'b00) begin
      bad++; $display("[TB] FAIL clear_stays_idle: state=%b want 00", bus_sat.state_o);
    end
  endtask

  task automatic test_cfg();
    logic [63:0] ds, dw;
    logic os, ow, v;
    start = 1'b1;
    step();
    start = 1'b0;
    evt_inc = '0;
    set_evt(1, 2'd1);
    set_evt(5, 2'd2);
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_sel = 3'd5;
    step();
    cfg_we = 1'b0;
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    evt_inc = '0;
    do_read(1, ds, os, dw, ow, v);
    total++;
    if (ds !== 64'd4) begin
      bad++; $display("[TB] FAIL cfg_run_ignored: cnt1=%0d want 4", ds);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_sel = 3'd5;
    step();
    cfg_we = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    set_evt(0, 2'd1);
    set_evt(1, 2'd1);
    set_evt(5, 2'd2);
    for (int c = 1; c <= 5; c++) begin
      stop = (c == 5);
      step();
    end
    stop = 1'b0;
    evt_inc = '0;
    do_read(1, ds, os, dw, ow, v);
    total++;
    if (ds !== 64'd10) begin
      bad++; $display("[TB] FAIL cfg_idle_applied: cnt1=%0d want 10", ds);
    end
    do_read(0, ds, os, dw, ow, v);
    total++;
    if (ds !== 64'd5) begin
      bad++; $display("[TB] FAIL cfg_cnt0_evt0: cnt0=%0d want 5", ds);
    end
    do_read(2, ds, os, dw, ow, v);
    total++;
    if (ds !== 64'd0) begin
      bad++; $display("[TB] FAIL cfg_cnt2: cnt2=%0d want 0", ds);
    end
  endtask

  task automatic test_back_to_back();
    clear = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    set_evt(0, 2'd1);
    for (int c = 1; c <= 6; c++) begin
      stop = (c == 6);
      step();
    end
    stop = 1'b0;
    evt_inc = '0;
    rd_req = 1'b1;
    rd_idx = 3'd0;
    step();
    total++;
    if (bus_sat.rd_valid_o !== 1'b1 || bus_sat.rd_data_o !== 64'd6) begin
      bad++; $display("[TB] FAIL b2b_cnt0: valid=%b data=%0d want 1/6", bus_sat.rd_valid_o, bus_sat.rd_data_o);
    end
    rd_idx = 3'd4;
    step();
    total++;
    if (bus_sat.rd_valid_o !== 1'b1 || bus_sat.rd_data_o !== 64'd6) begin
      bad++; $display("[TB] FAIL b2b_cycle: valid=%b data=%0d want 1/6", bus_sat.rd_valid_o, bus_sat.rd_data_o);
    end
    rd_idx = 3'd5;
    step();
    total++;
    if (bus_sat.rd_valid_o !== 1'b1 || bus_sat.rd_data_o !== 64'd0 || bus_sat.rd_ovf_o !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_idx5: valid=%b data=%0d ovf=%b want 1/0/0",
                      bus_sat.rd_valid_o, bus_sat.rd_data_o, bus_sat.rd_ovf_o);
    end
    rd_idx = 3'd0;
    step();
    total++;
    if (bus_sat.rd_valid_o !== 1'b1 || bus_sat.rd_data_o !== 64'd6) begin
      bad++; $display("[TB] FAIL b2b_cnt0_again: valid=%b data=%0d want 1/6", bus_sat.rd_valid_o, bus_sat.rd_data_o);
    end
    rd_req = 1'b0;
    step();
    total++;
    if (bus_sat.rd_valid_o !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_idle_valid: valid=%b want 0", bus_sat.rd_valid_o);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] ds, dw;
    logic os, ow, v;
    clear = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    set_evt(0, 2'd1);
    step();
    step();
    do_read(0, ds, os, dw, ow, v);
    total++;
    if (v !== 1'b1 || ds !== 64'd2) begin
      bad++; $display("[TB] FAIL midrun_pre_read: valid=%b data=%0d want 1/2", v, ds);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus_sat.state_o !== 2'b00 || bus_sat.rd_valid_o !== 1'b0 || bus_sat.done_o !== 1'b0) begin
      bad++; $display("[TB] FAIL midrun_async: state=%b valid=%b done=%b want 00/0/0",
                      bus_sat.state_o, bus_sat.rd_valid_o, bus_sat.done_o);
    end
    #1;
    rst = 1'b0;
    step();
    step();
    evt_inc = '0;
    do_read(0, ds, os, dw, ow, v);
    total++;
    if (ds !== 64'd0 || dw !== 64'd0) begin
      bad++; $display("[TB] FAIL midrun_cnt0: sat=%0d wrap=%0d want 0", ds, dw);
    end
    do_read(4, ds, os, dw, ow, v);
    total++;
    if (ds !== 64'd0) begin
      bad++; $display("[TB] FAIL midrun_cycle: data=%0d want 0", ds);
    end
    total++;
    if (bus_sat.state_o !== 2'b00) begin
      bad++; $display("[TB] FAIL midrun_idle: state=%b want 00", bus_sat.state_o);
    end
  endtask

  initial begin
    test_reset();
    test_run_halt();
    test_overflow();
    test_clear_start();
    test_cfg();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
